quad_port_ram: RTL and testbench
================================

Name: quad_port_ram

Overview:
- Synchronous RAM with four ports, parameterised in depth and width, used as a register-file/cache data store.
- Ports A and B are read/write ports. Ports C and D are read-only.
- All reads are registered: data appears one clock after the address is presented.
- Single clock domain with a synchronous, active-high reset that clears the output registers only.

Parameters:
- DEPTH, 4096, number of words stored.
- ADDR_WIDTH, 12, width of every address port.
- DATA_WIDTH, 32, width of every data and output port.
- Positional order is DEPTH, ADDR_WIDTH, DATA_WIDTH.

Ports:
- clk  in  1  clock; all activity on the rising edge.
- rst  in  1  synchronous active-high reset.
- data_a  in  DATA_WIDTH  write data, port A.
- data_b  in  DATA_WIDTH  write data, port B.
- addr_a  in  ADDR_WIDTH  address, port A (read/write).
- addr_b  in  ADDR_WIDTH  address, port B (read/write).
- addr_c  in  ADDR_WIDTH  address, port C (read-only).
- addr_d  in  ADDR_WIDTH  address, port D (read-only).
- we_a  in  1  write enable, port A.
- we_b  in  1  write enable, port B.
- q_a  out  DATA_WIDTH  registered read data, port A.
- q_b  out  DATA_WIDTH  registered read data, port B.
- q_c  out  DATA_WIDTH  registered read data, port C.
- q_d  out  DATA_WIDTH  registered read data, port D.

Behaviour:
- Memory array: DEPTH x DATA_WIDTH, zero-initialised at time 0 (simulation initial block / FPGA init). Never cleared by rst.
- Reset: on a rising edge with rst=1:
  - q_a..q_d <= 0.
  - Writes are suppressed.
  - Holding rst across several cycles keeps outputs at 0.
  - The first edge with rst=0 resumes normal operation.
- Write: on a rising edge with rst=0 and we_x=1, mem[addr_x] <= data_x (x = A or B).
- Read latency is 1 cycle. On every non-reset edge, q_x <= mem[addr_x] for all four ports. The output holds until the next edge.
- Read-during-write, same port (A or B): write-first. q_x <= data_x on the edge the port writes.
- Read-during-write, cross-port (any port reads an address another port writes on the same edge): returns the old contents. The new value is visible on the following edge.
- Simultaneous A and B writes to the same address: port B's data is stored. Port A's q_a still returns data_a (write-first on its own port).
- Address >= DEPTH (only possible when DEPTH < 2^ADDR_WIDTH):
  - Writes are ignored.
  - Reads return 0.
- Writes take effect only on the clock edge; there is no combinational path from any input to any q.
- No handshake, no stalls; every cycle accepts 2 writes and 4 reads.

Test Plan:
1. Reset and clear: assert rst for 2 edges with we_a=we_b=1 and data=0xFFFFFFFF at addr 5 -> q_a..q_d=0; after release, reading addr 5 on all ports returns 0 (writes were suppressed).
2. Basic write then read: write 11 to addr 10 via A -> q_a=11 on the same edge (write-first). Next edge, set addr_b=addr_c=addr_d=10 -> q_b=q_c=q_d=11 one cycle later. Addresses 1, 2, 3 read 0.
3. Dual write: one edge with A writing 111 to addr 0 and B writing 2100100100 to addr 22. Next edge, set addr_c=0, addr_d=22 -> q_c=111, q_d=2100100100.
4. Cross-port read-during-write: addr 30 holds 5; A writes 12345 to addr 30 while C reads addr 30 -> q_c=5 that edge, q_c=12345 the next edge.
5. Write collision: A writes 7 and B writes 9 to addr 40 on the same edge -> q_a=7, q_b=9. The next read of addr 40 on port C returns 9.
6. Reset mid-operation: with valid nonzero outputs, assert rst for 1 edge -> all q=0, memory contents intact. After release, rereading returns the previous data.

Source files
------------

// File: rtl/quad_port_ram.sv
// quad_port_ram: two read/write ports and two read-only ports, with registered reads
module quad_port_ram #(
  parameter int DEPTH = 4096,
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_a,
  input  logic [DATA_WIDTH-1:0] data_b,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  input  logic [ADDR_WIDTH-1:0] addr_c,
  input  logic [ADDR_WIDTH-1:0] addr_d,
  input  logic                  we_a,
  input  logic                  we_b,
  output logic [DATA_WIDTH-1:0] q_a,
  output logic [DATA_WIDTH-1:0] q_b,
  output logic [DATA_WIDTH-1:0] q_c,
  output logic [DATA_WIDTH-1:0] q_d
);
  logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};
  logic ok_a, ok_b, ok_c, ok_d;
  // addresses past the end of the array write nothing and read zero
  always_comb begin
    ok_a = 32'(addr_a) < DEPTH;
    ok_b = 32'(addr_b) < DEPTH;
    ok_c = 32'(addr_c) < DEPTH;
    ok_d = 32'(addr_d) < DEPTH;
  end
  // B is written after A, so B wins a same-address collision; reset leaves contents alone
  always_ff @(posedge clk) begin
    if (!rst && we_a && ok_a) mem[addr_a] <= data_a;
    if (!rst && we_b && ok_b) mem[addr_b] <= data_b;
  end
  // registered reads: write-first on the writing port, old data for the other ports
  always_ff @(posedge clk) begin
    if (rst) begin
      q_a <= '0;
      q_b <= '0;
      q_c <= '0;
      q_d <= '0;
    end else begin
      q_a <= !ok_a ? '0 : we_a ? data_a : mem[addr_a];
      q_b <= !ok_b ? '0 : we_b ? data_b : mem[addr_b];
      q_c <= ok_c ? mem[addr_c] : '0;
      q_d <= ok_d ? mem[addr_d] : '0;
    end
  end
endmodule

// File: tb/tb_quad_port_ram.sv
// tb_quad_port_ram: directed checks of reset, write-first, cross-port and collision behaviour
module tb_quad_port_ram;
  logic clk = 0;
  logic rst;
  logic [31:0] data_a, data_b, q_a, q_b, q_c, q_d;
  logic [11:0] addr_a, addr_b, addr_c, addr_d;
  logic we_a, we_b;
  int tests = 0;
  int fails = 0;

  quad_port_ram #(4096, 12, 32) dut (
    .clk(clk), .rst(rst),
    .data_a(data_a), .data_b(data_b),
    .addr_a(addr_a), .addr_b(addr_b), .addr_c(addr_c), .addr_d(addr_d),
    .we_a(we_a), .we_b(we_b),
    .q_a(q_a), .q_b(q_b), .q_c(q_c), .q_d(q_d)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1; we_a = 1; we_b = 1;
    data_a = 32'hFFFF_FFFF; data_b = 32'hFFFF_FFFF;
    addr_a = 5; addr_b = 5; addr_c = 5; addr_d = 5;
    step();
    chk("rst q_a", q_a, 0);
    chk("rst q_b", q_b, 0);
    chk("rst q_c", q_c, 0);
    chk("rst q_d", q_d, 0);
    step();
    chk("rst2 q_a", q_a, 0);
    rst = 0; we_a = 0; we_b = 0;
    step();
    chk("suppressed q_a", q_a, 0);
    chk("suppressed q_b", q_b, 0);
    chk("suppressed q_c", q_c, 0);
    chk("suppressed q_d", q_d, 0);

    we_a = 1; addr_a = 10; data_a = 11;
    step();
    chk("write-first q_a", q_a, 11);
    we_a = 0; addr_b = 10; addr_c = 10; addr_d = 10;
    step();
    chk("read10 q_b", q_b, 11);
    chk("read10 q_c", q_c, 11);
    chk("read10 q_d", q_d, 11);
    addr_a = 1; addr_b = 2; addr_c = 3;
    step();
    chk("empty q_a", q_a, 0);
    chk("empty q_b", q_b, 0);
    chk("empty q_c", q_c, 0);

    we_a = 1; addr_a = 0; data_a = 111;
    we_b = 1; addr_b = 22; data_b = 32'd2100100100;
    step();
    chk("dual q_b", q_b, 32'd2100100100);
    we_a = 0; we_b = 0; addr_c = 0; addr_d = 22;
    step();
    chk("dual q_c", q_c, 111);
    chk("dual q_d", q_d, 32'd2100100100);

    we_b = 1; addr_b = 30; data_b = 5;
    step();
    we_b = 0; we_a = 1; addr_a = 30; data_a = 12345; addr_c = 30;
    step();
    chk("rdw old q_c", q_c, 5);
    chk("rdw q_a", q_a, 12345);
    we_a = 0;
    step();
    chk("rdw new q_c", q_c, 12345);

    we_a = 1; we_b = 1; addr_a = 40; addr_b = 40; data_a = 7; data_b = 9;
    step();
    chk("collide q_a", q_a, 7);
    chk("collide q_b", q_b, 9);
    we_a = 0; we_b = 0; addr_c = 40;
    step();
    chk("collide q_c", q_c, 9);
    chk("collide q_a reread", q_a, 9);

    addr_d = 10;
    rst = 1;
    step();
    chk("midrst q_a", q_a, 0);
    chk("midrst q_b", q_b, 0);
    chk("midrst q_c", q_c, 0);
    chk("midrst q_d", q_d, 0);
    rst = 0;
    step();
    chk("post q_c", q_c, 9);
    chk("post q_a", q_a, 9);
    chk("post q_d", q_d, 11);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
